// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes and FSM state type shared by the ALU/MDU slice
package alu_pkg;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLL    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_SLT    = 4'd8;
    localparam logic [3:0] ALU_SLTU   = 4'd9;
    localparam logic [3:0] ALU_COPY_B = 4'd15;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

endpackage

// File: rtl/alu_mdu_if.sv
// rtl/alu_mdu_if.sv - request/result handshake bundle between a client and alu_mdu
interface alu_mdu_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic            ready_o;
    logic [4:0]      op_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic            flush_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] result_o;
    logic            zero_o;

    modport slave (
        input  valid_i, op_i, op1_i, op2_i, flush_i, ready_i,
        output ready_o, valid_o, result_o, zero_o
    );

    modport master (
        output valid_i, op_i, op1_i, op2_i, flush_i, ready_i,
        input  ready_o, valid_o, result_o, zero_o
    );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational base ALU; undefined op codes return zero
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);
    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_AND:    result = a & b;
            ALU_OR:     result = a | b;
            ALU_XOR:    result = a ^ b;
            ALU_SLL:    result = a << shamt;
            ALU_SRL:    result = a >> shamt;
            ALU_SRA:    result = $signed(a) >>> shamt;
            ALU_SLT:    result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:   result = {{(XLEN-1){1'b0}}, a < b};
            ALU_COPY_B: result = b;
            default:    result = '0;
        endcase
    end
endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - ALU plus iterative multiply/divide unit; divider built only with ALU_MDU_DIV_EN
module alu_mdu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    alu_mdu_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    state_t            state;
    logic [SHW-1:0]    cnt;
    logic [2:0]        mop_q;
    logic              sgn_lo;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc;
    logic              valid_q;
    logic              zero_q;
    logic [XLEN-1:0]   result_q;

    logic            is_m;
    logic [2:0]      m_op;
    logic            a_signed, b_signed, sa, sb;
    logic [XLEN-1:0] mag_a, mag_b, core_res, idle_res, fix_res;
    logic            idle_fast;

    assign is_m     = bus.op_i[4];
    assign m_op     = bus.op_i[2:0];
    assign a_signed = is_m && (m_op == MDU_MUL || m_op == MDU_MULH || m_op == MDU_MULHSU ||
                               m_op == MDU_DIV || m_op == MDU_REM);
    assign b_signed = is_m && (m_op == MDU_MUL || m_op == MDU_MULH ||
                               m_op == MDU_DIV || m_op == MDU_REM);
    assign sa       = a_signed & bus.op1_i[XLEN-1];
    assign sb       = b_signed & bus.op2_i[XLEN-1];
    assign mag_a    = sa ? -bus.op1_i : bus.op1_i;
    assign mag_b    = sb ? -bus.op2_i : bus.op2_i;

    alu_core #(.XLEN(XLEN)) u_core (
        .op     (bus.op_i[3:0]),
        .a      (bus.op1_i),
        .b      (bus.op2_i),
        .result (core_res)
    );

    // Shift-add step: multiplier sits in the low half and drains out as the product fills in
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, mul_fix;
    logic [XLEN-1:0]   mul_res;
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc[XLEN-1:1]};
    assign mul_fix  = sgn_lo ? -acc : acc;
    assign mul_res  = (mop_q == MDU_MUL) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];

`ifdef ALU_MDU_DIV_EN
    logic              sgn_hi;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_res, quo_fix, rem_fix;
    logic [XLEN:0]     div_shift, div_diff;
    logic [2*XLEN-1:0] div_next;

    assign div_zero    = (bus.op2_i == '0);
    assign div_ovf     = (m_op == MDU_DIV || m_op == MDU_REM) &&
                         (bus.op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.op2_i);
    assign special_res = div_zero ? (m_op[1] ? bus.op1_i : '1) : (m_op[1] ? '0 : bus.op1_i);

    // Restoring step: remainder in the high half, dividend/quotient shifting through the low half
    assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    assign quo_fix   = sgn_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_fix   = sgn_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    assign idle_fast = !is_m || (m_op[2] && (div_zero || div_ovf));
    assign idle_res  = !is_m ? core_res : special_res;
    assign fix_res   = mop_q[2] ? (mop_q[1] ? rem_fix : quo_fix) : mul_res;
`else
    assign idle_fast = !is_m || m_op[2];
    assign idle_res  = !is_m ? core_res : '0;
    assign fix_res   = mul_res;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            mop_q    <= '0;
            sgn_lo   <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            sgn_hi   <= 1'b0;
`endif
            opnd_q   <= '0;
            acc      <= '0;
            valid_q  <= 1'b0;
            zero_q   <= 1'b1;
            result_q <= '0;
        end else if (bus.flush_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.valid_i) begin
                        mop_q <= m_op;
                        cnt   <= '0;
                        if (idle_fast) begin
                            state    <= ST_DONE;
                            valid_q  <= 1'b1;
                            result_q <= idle_res;
                            zero_q   <= (idle_res == '0);
                        end else if (!m_op[2]) begin
                            state  <= ST_MUL;
                            acc    <= {{XLEN{1'b0}}, mag_b};
                            opnd_q <= mag_a;
                            sgn_lo <= sa ^ sb;
                        end
`ifdef ALU_MDU_DIV_EN
                        else begin
                            state  <= ST_DIV;
                            acc    <= {{XLEN{1'b0}}, mag_a};
                            opnd_q <= mag_b;
                            sgn_lo <= sa ^ sb;
                            sgn_hi <= sa;
                        end
`endif
                    end
                end
                ST_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == SHW'(XLEN-1)) state <= ST_FIX;
                end
`ifdef ALU_MDU_DIV_EN
                ST_DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == SHW'(XLEN-1)) state <= ST_FIX;
                end
`endif
                ST_FIX: begin
                    state    <= ST_DONE;
                    valid_q  <= 1'b1;
                    result_q <= fix_res;
                    zero_q   <= (fix_res == '0);
                end
                ST_DONE: begin
                    if (bus.ready_i) begin
                        state   <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready_o  = (state == ST_IDLE) && !bus.flush_i;
    assign bus.valid_o  = valid_q;
    assign bus.result_o = result_q;
    assign bus.zero_o   = zero_q;
endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - scoreboard bench for alu_mdu; expectations follow ALU_MDU_DIV_EN
module tb_alu_mdu;
    localparam logic [4:0] ADD = 5'h00, SUB = 5'h01, AND_ = 5'h02, OR_ = 5'h03, XOR_ = 5'h04;
    localparam logic [4:0] SLL = 5'h05, SRL = 5'h06, SRA = 5'h07, SLT = 5'h08, SLTU = 5'h09;
    localparam logic [4:0] BAD = 5'h0A, COPYB = 5'h0F;
    localparam logic [4:0] MUL = 5'h10, MULH = 5'h11, MULHSU = 5'h12, MULHU = 5'h13;
    localparam logic [4:0] DIV = 5'h14, DIVU = 5'h15, REM = 5'h16, REMU = 5'h17;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic prev_valid = 1'b0;

    logic [31:0] sb_res[$];
    logic        sb_z[$];
    int          sb_cyc[$];
    string       sb_name[$];

    alu_mdu_if #(.XLEN(32)) bus ();
    alu_mdu #(.XLEN(32)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.valid_o && !prev_valid) begin
                if (sb_res.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got result %h, required no result", bus.result_o);
                end else begin
                    chk({sb_name[0], "_res"}, bus.result_o, sb_res[0]);
                    chk({sb_name[0], "_zero"}, {31'd0, bus.zero_o}, {31'd0, sb_z[0]});
                    chk({sb_name[0], "_lat"}, cyc, sb_cyc[0]);
                    void'(sb_res.pop_front());
                    void'(sb_z.pop_front());
                    void'(sb_cyc.pop_front());
                    void'(sb_name.pop_front());
                end
            end
            prev_valid = bus.valid_o;
        end
    end

    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] r, input logic z, input int lat,
                        input string name);
        int n = 0;
        while (!bus.ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk({name, "_ready_timeout"}, {31'd0, bus.ready_o}, 32'd1);
        bus.op_i = op;
        bus.op1_i = a;
        bus.op2_i = b;
        bus.valid_i = 1'b1;
        if (push) begin
            sb_res.push_back(r);
            sb_z.push_back(z);
            sb_cyc.push_back(cyc + lat);
            sb_name.push_back(name);
        end
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb_res.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk({name, "_drain_timeout"}, sb_res.size(), 0);
            sb_res.delete();
            sb_z.delete();
            sb_cyc.delete();
            sb_name.delete();
        end
    endtask

    task automatic op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic z, input int lat, input string name);
        send(o, a, b, 1'b1, r, z, lat, name);
        drain(name);
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.op_i = '0;
        bus.op1_i = '0;
        bus.op2_i = '0;
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, bus.valid_o}, 32'd0);
        chk("rst_result", bus.result_o, 32'd0);
        chk("rst_zero", {31'd0, bus.zero_o}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.ready_o}, 32'd1);

        op(ADD,   32'd10,       32'd5,        32'h0000000F, 1'b0, 1, "add");
        op(SUB,   32'd20,       32'd20,       32'h00000000, 1'b1, 1, "sub");
        op(AND_,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1, "and");
        op(OR_,   32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1, "or");
        op(XOR_,  32'h000000FF, 32'h0000000F, 32'h000000F0, 1'b0, 1, "xor");
        op(SLL,   32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1, "sll_upper_ignored");
        op(SRL,   32'h80000000, 32'd31,       32'h00000001, 1'b0, 1, "srl31");
        op(SRA,   32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1, "sra");
        op(SLT,   32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b0, 1, "slt");
        op(SLTU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b1, 1, "sltu");
        op(COPYB, 32'hDEADBEEF, 32'h00001234, 32'h00001234, 1'b0, 1, "copyb");
        op(BAD,   32'd5,        32'd5,        32'h00000000, 1'b1, 1, "undef_op");

        op(MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 34, "mulh");
        op(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34, "mulhu");
        op(MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 34, "mul_neg");
        op(MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, 34, "mulhsu");
        op(5'h18,  32'd6,        32'd7,        32'd42,       1'b0, 34, "mul_bit3_ignored");

`ifdef ALU_MDU_DIV_EN
        op(DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 34, "div_neg");
        op(REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 34, "rem_neg");
        op(DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1,  "divu_by0");
        op(REM,  32'd5,        32'd0,        32'd5,        1'b0, 1,  "rem_by0");
        op(DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1,  "div_ovf");
        op(REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1,  "rem_ovf");
        op(DIVU, 32'd100,      32'd7,        32'd14,       1'b0, 34, "divu");
        op(REMU, 32'd100,      32'd7,        32'd2,        1'b0, 34, "remu");
        op(DIVU, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 1'b0, 34, "divu_big");
`else
        op(DIV,  32'd100,      32'd7,        32'd0,        1'b1, 1,  "div_disabled");
        op(REMU, 32'd100,      32'd7,        32'd0,        1'b1, 1,  "remu_disabled");
        op(MUL,  32'd6,        32'd7,        32'd42,       1'b0, 34, "mul_6x7");
`endif

        // Backpressure: result must sit still while the consumer stalls
        bus.ready_i = 1'b0;
        send(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 1'b0, 34, "mulhu_hold");
        begin
            int n = 0;
            while (!bus.valid_o && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("hold_valid_seen", {31'd0, bus.valid_o}, 32'd1);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_result", bus.result_o, 32'hFFFFFFFE);
            chk("hold_valid", {31'd0, bus.valid_o}, 32'd1);
            chk("hold_ready", {31'd0, bus.ready_o}, 32'd0);
        end
        bus.ready_i = 1'b1;
        @(negedge clk);
        chk("release_valid", {31'd0, bus.valid_o}, 32'd0);
        chk("release_ready", {31'd0, bus.ready_o}, 32'd1);

        // Flush mid-iteration: nothing may come out of the aborted op
`ifdef ALU_MDU_DIV_EN
        send(DIV, 32'd1000, 32'd3, 1'b0, 32'd0, 1'b0, 0, "flushed");
`else
        send(MUL, 32'd1000, 32'd3, 1'b0, 32'd0, 1'b0, 0, "flushed");
`endif
        repeat (5) @(negedge clk);
        bus.flush_i = 1'b1;
        #1 chk("flush_ready_low", {31'd0, bus.ready_o}, 32'd0);
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        chk("flush_idle_ready", {31'd0, bus.ready_o}, 32'd1);
        chk("flush_valid", {31'd0, bus.valid_o}, 32'd0);
        op(ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1, "add_after_flush");
        repeat (40) @(negedge clk);

        // Reset in the middle of a multiply
        send(MUL, 32'd9, 32'd9, 1'b0, 32'd0, 1'b0, 0, "reset_mul");
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, bus.valid_o}, 32'd0);
        chk("midrst_result", bus.result_o, 32'd0);
        chk("midrst_zero", {31'd0, bus.zero_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {31'd0, bus.ready_o}, 32'd1);
        repeat (40) @(negedge clk);
        op(MUL, 32'd6, 32'd7, 32'd42, 1'b0, 34, "mul_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter XLEN, default 32, operand/result width in bits; legal values 32 and 64.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  asynchronous, active-low reset.
REQ-004 valid_i  input  1  request valid.
REQ-005 ready_o  output  1  unit can accept a request this cycle.
REQ-006 op_i  input  5  operation: bit4=0 base ALU op, bit4=1 M-extension op.
REQ-007 op1_i  input  XLEN  operand A.
REQ-008 op2_i  input  XLEN  operand B.
REQ-009 flush_i  input  1  abort any in-flight operation.
REQ-010 valid_o  output  1  result valid.
REQ-011 ready_i  input  1  consumer accepts result.
REQ-012 result_o  output  XLEN  result.
REQ-013 zero_o  output  1  result_o == 0.

Function
REQ-014 Base op codes (op_i[3:0]): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 15 COPY_B; other codes yield result 0, zero_o 1.
REQ-015 Shift amount = op2_i[log2(XLEN)-1:0]; upper bits ignored.
REQ-016 M op codes (op_i[2:0]): 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU; op_i[3] ignored when op_i[4]=1.
REQ-017 Request accepted in a cycle where valid_i && ready_o && !flush_i; operands and op captured at that edge.
REQ-018 ready_o = 1 only in IDLE and not while flush_i is high.
REQ-019 FSM states IDLE, MUL, DIV, FIX, DONE; IDLE->DONE (base op or DIV special case), IDLE->MUL, IDLE->DIV, MUL/DIV->FIX after exactly XLEN iteration cycles, FIX->DONE, DONE->IDLE when ready_i.
REQ-020 Base op: valid_o asserted the cycle after acceptance (latency 1).
REQ-021 Multiply: radix-2 shift-add on operand magnitudes; FIX applies sign; valid_o at acceptance+XLEN+2.
REQ-022 Divide: restoring, one quotient bit per cycle on magnitudes; FIX applies signs (quotient sign = signA^signB, remainder sign = signA); latency XLEN+2.
REQ-023 Divide by zero: quotient all-ones, remainder = op1_i, latency 1, no iteration.
REQ-024 Signed overflow (DIV/REM, op1 = most-negative, op2 = -1): quotient = op1_i, remainder 0, latency 1.
REQ-025 In DONE, result_o/zero_o/valid_o held stable until ready_i; valid_o deasserts the cycle after the handshake.
REQ-026 flush_i in any state: next state IDLE, valid_o 0 next cycle, no result produced; flush_i in DONE discards the held result.
REQ-027 result_o holds the last value outside DONE; valid_o is the only qualifier.

Reset
REQ-028 On rst_ni low: state IDLE, valid_o 0, result_o 0, zero_o 1, ready_o 1 after release, iteration counter 0.
REQ-029 Reset mid-operation discards the operation; no valid_o after release without a new request.

Configuration
REQ-030 Macro ALU_MDU_DIV_EN defined: DIV/DIVU/REM/REMU implemented per REQ-022..024.
REQ-031 Macro undefined: divider datapath and DIV state absent; divide ops complete with latency 1, result 0, zero_o 1; multiply and base ops unchanged.

Structure
REQ-032 Package alu_pkg holds base and M op code localparams, FSM state typedef, and XLEN-independent constants.
REQ-033 Sub-module alu_core: purely combinational base ALU (REQ-014/015), parametrised by XLEN, instantiated once.

Verification
REQ-034 XLEN=32, ADD 10+5 -> result 0x0000000F, zero_o 0, valid_o one cycle after accept; SUB 20-20 -> 0, zero_o 1.
REQ-035 MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MUL 7 x -3 -> 0xFFFFFFEB; valid_o exactly 34 cycles after accept.
REQ-036 DIV -7/2 -> 0xFFFFFFFD, REM -7%2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF (1 cycle); DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
REQ-037 MULHU issued, ready_i held 0 for 10 cycles after valid_o -> result stable, ready_o 0 throughout; ready_i 1 -> valid_o 0 next cycle, ready_o 1.
REQ-038 DIV issued, flush_i pulsed at iteration 5 -> no valid_o, IDLE next cycle, immediate new ADD completes correctly; rst_ni pulsed mid-MUL -> outputs per REQ-028.
REQ-039 Build without ALU_MDU_DIV_EN: DIV 100/7 -> result 0, zero_o 1, latency 1; MUL 6x7 -> 42.
